factorial_ctrl: RTL

FACTORIAL_CTRL -- requirements
Module: factorial_ctrl

---
 rtl/factorial_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/factorial_ctrl.sv
// -----------------------------------------------------------------------------
// factorial_ctrl
//   Iterative n! controller that drives an external combinational multiplier.
//   A level request 'go' sampled in IDLE starts a computation of n!. Each cycle
//   in CALC multiplies the running product by a down-counter until the counter
//   reaches 1. An operand above N_MAX is rejected immediately with 'err'. The
//   result is held in DONE/ERR until 'go' is dropped, which acts as the
//   completion acknowledge.
//
// Ports
//   clk    in   1        rising-edge clock
//   rst    in   1        asynchronous, active-low reset
//   go     in   1        level request / acknowledge (sampled in IDLE, DONE, ERR)
//   n      in   N_WIDTH  operand, latched when go is sampled in IDLE
//   mul_x  out  WIDTH    multiplier operand = running product register
//   mul_y  out  WIDTH    multiplier operand = counter register, zero-extended
//   mul_z  in   WIDTH    multiplier result (combinational, truncated)
//   busy   out  1        high in CALC
//   done   out  1        high in DONE
//   err    out  1        high in ERR
//   nf     out  WIDTH    registered result n!
// -----------------------------------------------------------------------------
module factorial_ctrl #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 4,
  parameter int N_MAX   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [N_WIDTH-1:0] n,
  output logic [WIDTH-1:0]   mul_x,
  output logic [WIDTH-1:0]   mul_y,
  input  logic [WIDTH-1:0]   mul_z,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   nf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [N_WIDTH-1:0] N_LIMIT = N_WIDTH'(N_MAX);
  localparam logic [N_WIDTH-1:0] CNT_ONE = N_WIDTH'(1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     prod_q,  prod_d;
  logic [N_WIDTH-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]     nf_q,    nf_d;

  // Next-state and datapath update.
  // NOTE: every variable gets a default first so no path through the case
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    nf_d    = nf_q;

    case (state_q)
      IDLE: begin
        if (go) begin
          nf_d = '0;
          if (n > N_LIMIT) begin
            // Reject before touching the datapath; prod/cnt keep their values.
            state_d = ERR;
          end else begin
            cnt_d   = n;
            prod_d  = WIDTH'(1);
            state_d = CALC;
          end
        end
      end

      CALC: begin
        // cnt<=1 covers n=0 and n=1: no multiply, prod is already the answer.
        if (cnt_q <= CNT_ONE) begin
          nf_d    = prod_q;
          state_d = DONE;
        end else begin
          prod_d = mul_z;
          cnt_d  = cnt_q - CNT_ONE;
        end
      end

      DONE, ERR: begin
        if (!go) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  // NOTE: all registers are reset asynchronously; the operands seen by the
  // multiplier and the result port read zero while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      prod_q  <= '0;
      cnt_q   <= '0;
      nf_q    <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      nf_q    <= nf_d;
    end
  end

  // Multiplier operands come straight from registers: no input reaches them
  // combinationally, so mul_z can be a long path without forming a loop.
  assign mul_x = prod_q;
  assign mul_y = WIDTH'(cnt_q);

  assign busy  = (state_q == CALC);
  assign done  = (state_q == DONE);
  assign err   = (state_q == ERR);
  assign nf    = nf_q;

endmodule
